// File: rtl/dispense_pkg.sv
// Shared types and sizing helpers for the dispense scheduler slice.
package dispense_pkg;

  localparam int CMD_W = 5;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_WAIT  = 3'd2,
    S_DONE  = 3'd3,
    S_FAULT = 3'd4
  } state_t;

  // Width of a counter that must hold any value up to max(a, b).
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/dispense_fifo.sv
// Synchronous command FIFO with a combinational read head.
module dispense_fifo
  import dispense_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = CMD_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  // A full queue never takes a push, even when the head leaves in the same cycle.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr];

  // Storage write port.
  // NOTE: the storage array has no reset; pointers and count alone define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is a power of 2).
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/dispense_scheduler.sv
// Queues dispatch commands and sequences the motors one product at a time:
// run the motor, wait for the drop sensor, retry once, else hold in fault.
module dispense_scheduler
  import dispense_pkg::*;
#(
  parameter int MOTOR_CYCLES   = 8,
  parameter int TIMEOUT_CYCLES = 32,
  parameter int DEPTH          = 4,
  parameter int MAX_RETRY      = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  input  logic [CMD_W-1:0] cmd,
  output logic             cmd_ready,
  input  logic             drop_sense,
  input  logic             fault_clr,
  output logic [CMD_W-1:0] motor,
  output logic             busy,
  output logic             done,
  output logic             fault
);

  localparam int CNT_W   = cnt_width(MOTOR_CYCLES, TIMEOUT_CYCLES);
  localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [CNT_W-1:0]   RUN_LAST  = CNT_W'(MOTOR_CYCLES - 1);
  localparam logic [CNT_W-1:0]   WAIT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

  state_t             state, state_n;
  logic [CMD_W-1:0]   cur, cur_n;
  logic [RETRY_W-1:0] retry, retry_n;
  logic               seen, seen_n;
  logic [CNT_W-1:0]   run_cnt, run_cnt_n;
  logic [CNT_W-1:0]   wait_cnt, wait_cnt_n;
  logic [CMD_W-1:0]   motor_n;
  logic               done_n;
  logic               fault_n;

  logic               push;
  logic               pop;
  logic [CMD_W-1:0]   head;
  logic               full;
  logic               empty;

  assign cmd_ready = ~full & ~fault;
  assign push      = cmd_valid & cmd_ready & (cmd != '0);
  assign pop       = (state == S_IDLE) & ~empty;
  // The done term keeps busy high through the pulse so it falls only afterwards.
  assign busy      = ~empty | (state != S_IDLE) | done;

  dispense_fifo #(
    .DEPTH (DEPTH),
    .W     (CMD_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (cmd),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  // Next-state, datapath and registered-output decode.
  // NOTE: every signal gets a default first so no path through the case infers a latch.
  always_comb begin
    state_n    = state;
    cur_n      = cur;
    retry_n    = retry;
    seen_n     = seen;
    run_cnt_n  = run_cnt;
    wait_cnt_n = wait_cnt;

    case (state)
      S_IDLE: begin
        if (!empty) begin
          cur_n     = head;
          retry_n   = '0;
          seen_n    = 1'b0;
          run_cnt_n = '0;
          state_n   = S_RUN;
        end
      end
      S_RUN: begin
        if (drop_sense) seen_n = 1'b1;
        if (run_cnt == RUN_LAST) begin
          run_cnt_n  = '0;
          wait_cnt_n = '0;
          state_n    = (seen | drop_sense) ? S_DONE : S_WAIT;
        end else begin
          run_cnt_n = run_cnt + 1'b1;
        end
      end
      S_WAIT: begin
        // A drop on the final timeout cycle still counts as success.
        if (drop_sense) begin
          state_n = S_DONE;
        end else if (wait_cnt == WAIT_LAST) begin
          if (retry < RETRY_MAX) begin
            retry_n   = retry + 1'b1;
            seen_n    = 1'b0;
            run_cnt_n = '0;
            state_n   = S_RUN;
          end else begin
            state_n = S_FAULT;
          end
        end else begin
          wait_cnt_n = wait_cnt + 1'b1;
        end
      end
      S_DONE: begin
        cur_n   = '0;
        state_n = S_IDLE;
      end
      S_FAULT: begin
        if (fault_clr) begin
          cur_n   = '0;
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase

    // Motor and done trail the state by one clock; fault tracks the FAULT state itself.
    motor_n = (state == S_RUN) ? cur : '0;
    done_n  = (state == S_DONE);
    fault_n = (state_n == S_FAULT);
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  // Datapath registers and registered outputs; reset drops the motor at the next edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      cur      <= '0;
      retry    <= '0;
      seen     <= 1'b0;
      run_cnt  <= '0;
      wait_cnt <= '0;
      motor    <= '0;
      done     <= 1'b0;
      fault    <= 1'b0;
    end else begin
      cur      <= cur_n;
      retry    <= retry_n;
      seen     <= seen_n;
      run_cnt  <= run_cnt_n;
      wait_cnt <= wait_cnt_n;
      motor    <= motor_n;
      done     <= done_n;
      fault    <= fault_n;
    end
  end

endmodule

// File: tb/tb_dispense_scheduler.sv
// Directed bench for dispense_scheduler: a cycle table for a single dispatch,
// then hand-written sequences for queueing, retry, fault, early drop and reset.
module tb_dispense_scheduler;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [4:0] cmd = 5'd0;
  logic       cmd_ready;
  logic       drop_sense = 1'b0;
  logic       fault_clr = 1'b0;
  logic [4:0] motor;
  logic       busy;
  logic       done;
  logic       fault;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       valid;
    logic [4:0] cmd;
    logic       drop;
    logic       clr;
    logic [4:0] motor;
    logic       done;
    logic       busy;
    logic       fault;
    logic       ready;
  } vec_t;

  localparam int NV = 17;
  vec_t vt [NV];

  dispense_scheduler dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd        (cmd),
    .cmd_ready  (cmd_ready),
    .drop_sense (drop_sense),
    .fault_clr  (fault_clr),
    .motor      (motor),
    .busy       (busy),
    .done       (done),
    .fault      (fault)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    cmd_valid  = 1'b0;
    cmd        = 5'd0;
    drop_sense = 1'b0;
    fault_clr  = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic push_cmd(input logic [4:0] c);
    cmd_valid = 1'b1;
    cmd       = c;
    tick();
    cmd_valid = 1'b0;
    cmd       = 5'd0;
  endtask

  // Wait for a motor burst, check its code and length, then the done behaviour right after it.
  task automatic burst(input logic [4:0] exp, input int exp_len, input bit pulse,
                       input bit exp_done, input string nm);
    int n;
    int len;
    n = 0;
    while (motor == 5'd0 && n < 400) begin
      tick();
      n++;
    end
    check($sformatf("%s start", nm), motor, exp);
    len = 0;
    while (motor == exp && len < 100) begin
      len++;
      if (pulse && len == 1) drop_sense = 1'b1;
      tick();
      if (pulse) drop_sense = 1'b0;
    end
    check($sformatf("%s length", nm), len, exp_len);
    check($sformatf("%s done", nm), done, exp_done);
    if (exp_done) begin
      tick();
      check($sformatf("%s done width", nm), done, 1'b0);
    end
  endtask

  // Count idle motor clocks between attempts and any done seen in that gap.
  task automatic gap(input int exp_len, input string nm);
    int n;
    int d;
    n = 0;
    d = 0;
    while (motor == 5'd0 && n < 200) begin
      if (done) d++;
      tick();
      n++;
    end
    check($sformatf("%s gap", nm), n, exp_len);
    check($sformatf("%s gap done", nm), d, 0);
  endtask

  // Run idle for a while and report whether the motor ever moved.
  task automatic quiet(input int cycles, input string nm);
    logic any;
    any = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (motor != 5'd0) any = 1'b1;
    end
    check($sformatf("%s motor idle", nm), any, 1'b0);
    check($sformatf("%s busy", nm), busy, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;

    // Single dispatch: command 10001, drop on the third WAIT cycle.
    for (int i = 0; i < NV; i++)
      vt[i] = '{valid: 1'b0, cmd: 5'd0, drop: 1'b0, clr: 1'b0,
                motor: 5'd0, done: 1'b0, busy: 1'b1, fault: 1'b0, ready: 1'b1};
    vt[0].valid = 1'b1;
    vt[0].cmd   = 5'b10001;
    for (int i = 2; i <= 9; i++) vt[i].motor = 5'b10001;
    vt[12].drop  = 1'b1;
    vt[13].done  = 1'b1;
    vt[14].busy  = 1'b0;
    vt[15].valid = 1'b1;
    vt[15].busy  = 1'b0;
    vt[16].busy  = 1'b0;

    do_reset();
    check("reset motor", motor, 5'd0);
    check("reset done", done, 1'b0);
    check("reset fault", fault, 1'b0);
    check("reset busy", busy, 1'b0);
    check("reset ready", cmd_ready, 1'b1);

    for (int i = 0; i < NV; i++) begin
      cmd_valid  = vt[i].valid;
      cmd        = vt[i].cmd;
      drop_sense = vt[i].drop;
      fault_clr  = vt[i].clr;
      tick();
      check($sformatf("t1 vec%0d {motor,done,busy,fault,ready}", i),
            {motor, done, busy, fault, cmd_ready},
            {vt[i].motor, vt[i].done, vt[i].busy, vt[i].fault, vt[i].ready});
    end
    cmd_valid = 1'b0;

    // Queue full: A starts, B..E fill the queue, F is refused; A..E run in order.
    do_reset();
    drop_sense = 1'b1;
    push_cmd(5'd1);
    push_cmd(5'd2);
    push_cmd(5'd3);
    push_cmd(5'd4);
    check("t2 ready before last", cmd_ready, 1'b1);
    push_cmd(5'd5);
    check("t2 ready when full", cmd_ready, 1'b0);
    push_cmd(5'd6);
    burst(5'd1, 5, 0, 1, "t2 A");
    burst(5'd2, 8, 0, 1, "t2 B");
    burst(5'd3, 8, 0, 1, "t2 C");
    burst(5'd4, 8, 0, 1, "t2 D");
    burst(5'd5, 8, 0, 1, "t2 E");
    drop_sense = 1'b0;
    quiet(12, "t2 after");

    // Retry: first attempt times out, second attempt sees the drop.
    do_reset();
    push_cmd(5'd9);
    burst(5'd9, 8, 0, 0, "t3 try1");
    gap(32, "t3");
    burst(5'd9, 8, 1, 1, "t3 try2");
    check("t3 busy after", busy, 1'b0);

    // Fault: two failed attempts, pushes refused, clear releases the next command.
    do_reset();
    push_cmd(5'd12);
    push_cmd(5'd13);
    burst(5'd12, 8, 0, 0, "t4 try1");
    gap(32, "t4");
    burst(5'd12, 8, 0, 0, "t4 try2");
    n = 0;
    while (!fault && n < 100) begin
      tick();
      n++;
    end
    check("t4 fault", fault, 1'b1);
    check("t4 fault latency", n, 31);
    check("t4 motor in fault", motor, 5'd0);
    check("t4 ready in fault", cmd_ready, 1'b0);
    check("t4 busy in fault", busy, 1'b1);
    push_cmd(5'd14);
    tick();
    check("t4 fault held", fault, 1'b1);
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    check("t4 fault cleared", fault, 1'b0);
    check("t4 ready after clear", cmd_ready, 1'b1);
    drop_sense = 1'b1;
    burst(5'd13, 8, 0, 1, "t4 next");
    drop_sense = 1'b0;
    quiet(12, "t4 after");

    // Early drop on RUN cycle 2: done straight after the motor phase, no WAIT.
    do_reset();
    push_cmd(5'd21);
    burst(5'd21, 8, 1, 1, "t5");
    check("t5 busy after", busy, 1'b0);

    // Reset in the middle of RUN with three commands queued.
    do_reset();
    push_cmd(5'd17);
    push_cmd(5'd18);
    push_cmd(5'd19);
    push_cmd(5'd20);
    check("t6 running", motor, 5'd17);
    check("t6 busy before", busy, 1'b1);
    reset = 1'b1;
    tick();
    check("t6 motor after reset", motor, 5'd0);
    check("t6 busy after reset", busy, 1'b0);
    check("t6 ready after reset", cmd_ready, 1'b1);
    reset = 1'b0;
    push_cmd(5'd0);
    check("t6 zero cmd ignored", busy, 1'b0);
    quiet(14, "t6 after");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
